// File: rtl/tdc_multich_uart.sv
// tdc_multich_uart
//   Multi-channel coarse time-to-digital converter with UART readout.
//   A rising edge on start arms a shared cycle counter; each stop channel
//   timestamps its first rising edge. Once every channel has fired, or the
//   counter saturates, one 8N1 frame is sent on tx:
//     {4'hA, mask}, then channel 0..N_CH-1 timestamps, MSB byte first.
//   The end of the frame is flagged by a one-cycle pulse on eot.
//
// Ports
//   clk    in            system clock, rising edge
//   rst_n  in            asynchronous active-low reset
//   start  in            async pin, rising edge arms a measurement
//   stop   in  [N_CH]    async pins, rising edge timestamps channel i
//   tx     out           UART serial out, idle high
//   eot    out           one-cycle pulse after the last stop bit
//   busy   out           high while ARMED or SEND

module tdc_multich_uart #(
    parameter int N_CH         = 2,
    parameter int CNT_W        = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N_CH-1:0] stop,
    output logic            tx,
    output logic            eot,
    output logic            busy
);

    localparam int NBYTES  = 1 + N_CH * CNT_W / 8;
    localparam int FRAME_W = NBYTES * 8;
    localparam int BYTE_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CLK_W   = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    // Synchroniser (s1, s2) plus edge-detect history (s3)
    logic            start_s1_q, start_s2_q, start_s3_q;
    logic [N_CH-1:0] stop_s1_q, stop_s2_q, stop_s3_q;

    logic [1:0]                  state_q,    state_d;
    logic [CNT_W-1:0]            cnt_q,      cnt_d;
    logic [N_CH-1:0]             captured_q, captured_d;
    logic [N_CH-1:0][CNT_W-1:0]  cap_q,      cap_d;
    logic                        tx_q,       tx_d;
    logic                        busy_q,     busy_d;
    logic                        eot_q,      eot_d;
    logic [CLK_W-1:0]            clk_cnt_q,  clk_cnt_d;
    logic [3:0]                  bit_q,      bit_d;
    logic [BYTE_W-1:0]           byte_q,     byte_d;

    logic                        start_rise;
    logic [N_CH-1:0]             stop_rise;
    logic [CNT_W-1:0]            stamp;
    logic [3:0]                  mask;
    logic [FRAME_W-1:0]          frame;
    logic [7:0]                  cur_byte;

    assign start_rise = start_s2_q & ~start_s3_q;
    assign stop_rise  = stop_s2_q & ~stop_s3_q;

    // The counter reads 0 in the first ARMED cycle, which is already one
    // cycle after the start edge was seen. Storing counter+1 makes the stamp
    // equal to the pin-to-pin delay; it saturates with the counter.
    assign stamp = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

    always_comb begin
        mask = 4'h0;
        for (int i = 0; i < N_CH; i++) begin
            mask[i] = captured_q[i];
        end
        frame = '0;
        frame[FRAME_W-1 -: 8] = {4'hA, mask};
        for (int i = 0; i < N_CH; i++) begin
            frame[(N_CH-1-i)*CNT_W +: CNT_W] = cap_q[i];
        end
    end

    always_comb begin
        cur_byte = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (byte_q == BYTE_W'(b)) begin
                cur_byte = frame[(NBYTES-1-b)*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        cap_d      = cap_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        eot_d      = 1'b0;
        clk_cnt_d  = clk_cnt_q;
        bit_d      = bit_q;
        byte_d     = byte_q;

        case (state_q)
            IDLE: begin
                captured_d = '0;
                cap_d      = '1;
                tx_d       = 1'b1;
                if (start_rise) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            ARMED: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (stop_rise[i] && !captured_q[i]) begin
                        captured_d[i] = 1'b1;
                        cap_d[i]      = stamp;
                    end
                end
                // Exit looks at this cycle's captures as well
                if ((&captured_d) || (cnt_q == CNT_MAX)) begin
                    state_d   = SEND;
                    tx_d      = 1'b0;
                    clk_cnt_d = '0;
                    bit_d     = 4'd0;
                    byte_d    = '0;
                end
            end

            SEND: begin
                // bit_q: 0 = start bit, 1..8 = data LSB first, 9 = stop bit
                if (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        if (byte_q == BYTE_W'(NBYTES - 1)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            eot_d   = 1'b1;
                            tx_d    = 1'b1;
                        end else begin
                            byte_d = byte_q + BYTE_W'(1);
                            bit_d  = 4'd0;
                            tx_d   = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
            stop_s1_q  <= '0;
            stop_s2_q  <= '0;
            stop_s3_q  <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            captured_q <= '0;
            cap_q      <= '1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            eot_q      <= 1'b0;
            clk_cnt_q  <= '0;
            bit_q      <= 4'd0;
            byte_q     <= '0;
        end else begin
            start_s1_q <= start;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
            stop_s1_q  <= stop;
            stop_s2_q  <= stop_s1_q;
            stop_s3_q  <= stop_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            cap_q      <= cap_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            eot_q      <= eot_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
        end
    end

    assign tx   = tx_q;
    assign eot  = eot_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_tdc_multich_uart.sv
// Bench for tdc_multich_uart: instance 0 uses CNT_W=16, instance 1 CNT_W=8,
// both N_CH=2, CLKS_PER_BIT=4. A behavioural model predicts, from the pin
// activity of each measurement, the arm cycle, the frame bytes and the SEND
// window; one compare process checks {tx,busy,eot} of both instances every
// cycle.

module tb_tdc_multich_uart;

    localparam int CPB = 4;

    typedef struct {
        int off;   // cycle offset from the start pin rise
        int pin;   // -1 = start, 0..1 = stop channel
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [1:0] stop0 = 2'b00, stop1 = 2'b00;
    logic       tx0, eot0, busy0, tx1, eot1, busy1;

    always #5 clk = ~clk;

    tdc_multich_uart #(.N_CH(2), .CNT_W(16), .CLKS_PER_BIT(CPB)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0),
        .tx(tx0), .eot(eot0), .busy(busy0));

    tdc_multich_uart #(.N_CH(2), .CNT_W(8), .CLKS_PER_BIT(CPB)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1),
        .tx(tx1), .eot(eot1), .busy(busy1));

    longint     cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         total = 0;
    int         bad = 0;
    logic       chk_en = 1'b0;

    // Model state per instance
    longint     mA[2] = '{-10, -10};   // first ARMED cycle
    longint     mS[2] = '{-10, -10};   // first SEND cycle
    longint     mE[2] = '{-10, -10};   // eot cycle
    logic [7:0] mb[2][9];
    int         mnb[2] = '{0, 0};
    int         mmax[2] = '{65535, 255};
    longint     n_g;
    ev_t        evq[$];

    function automatic logic [2:0] expv(input int k, input longint c);
        logic t, b, e;
        longint j;
        int bi, by;
        t = 1'b1;
        b = (c >= mA[k]) && (c < mE[k]);
        e = (c == mE[k]);
        if (c >= mS[k] && c < mE[k]) begin
            j  = c - mS[k];
            bi = int'((j / CPB) % 10);
            by = int'(j / (CPB * 10));
            if (bi == 0)      t = 1'b0;
            else if (bi == 9) t = 1'b1;
            else              t = mb[k][by][bi-1];
        end
        return {t, b, e};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [2:0] ex, ac;
                ex = expv(k, cyc);
                ac = (k == 0) ? {tx0, busy0, eot0} : {tx1, busy1, eot1};
                total++;
                if (ac !== ex) begin
                    bad++;
                    $display("FAIL out%0d cyc=%0d {tx,busy,eot} got=%b want=%b", k, cyc, ac, ex);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic add(input int off, input int pin);
        ev_t e;
        e.off = off;
        e.pin = pin;
        evq.push_back(e);
    endtask

    // Work out the whole measurement from the stop schedule
    task automatic setup(input int k);
        int     d[2];
        bit     has[2];
        bit     cap[2];
        longint x, cand, r0, r1;
        int     st[2];
        n_g = cyc + 10;
        for (int c = 0; c < 2; c++) begin
            has[c] = 1'b0;
            d[c] = 0;
            foreach (evq[i]) begin
                if (evq[i].pin == c && evq[i].off >= 1 && (!has[c] || evq[i].off < d[c])) begin
                    has[c] = 1'b1;
                    d[c] = evq[i].off;
                end
            end
        end
        mA[k] = n_g + 3;
        cand = mA[k] + mmax[k];
        r0 = n_g + d[0] + 2;
        r1 = n_g + d[1] + 2;
        if (has[0] && has[1]) x = (r0 > r1) ? r0 : r1;
        else x = cand;
        if (x > cand) x = cand;
        for (int c = 0; c < 2; c++) begin
            cap[c] = has[c] && (n_g + d[c] + 2 <= x);
            st[c]  = cap[c] ? ((d[c] < mmax[k]) ? d[c] : mmax[k]) : mmax[k];
        end
        mb[k][0] = {4'hA, 2'b00, cap[1], cap[0]};
        if (k == 0) begin
            for (int c = 0; c < 2; c++) begin
                mb[k][1+2*c] = 8'(st[c] >> 8);
                mb[k][2+2*c] = 8'(st[c]);
            end
            mnb[k] = 5;
        end else begin
            for (int c = 0; c < 2; c++) mb[k][1+c] = 8'(st[c]);
            mnb[k] = 3;
        end
        mS[k] = x + 1;
        mE[k] = mS[k] + longint'(mnb[k] * 10 * CPB);
    endtask

    task automatic chk_frame(input string nm, input int k, input logic [63:0] want, input int nb);
        logic [63:0] g;
        g = '0;
        for (int i = 0; i < mnb[k]; i++) g = {g[55:0], mb[k][i]};
        chk({nm, "_len"}, 64'(mnb[k]), 64'(nb));
        chk(nm, g, want);
    endtask

    // Play the schedule cycle by cycle; ss = start pulse offset inside SEND,
    // rst_at = cycle offset inside SEND at which reset is asserted
    task automatic drive(input int k, input int ss, input int rst_at);
        logic   stp;
        logic [1:0] sp;
        longint r;
        while (cyc <= mE[k]) begin
            stp = (cyc - n_g >= 0) && (cyc - n_g <= 1);
            sp = 2'b00;
            foreach (evq[i]) begin
                r = cyc - (n_g + evq[i].off);
                if (r >= 0 && r <= 1) begin
                    if (evq[i].pin < 0) stp = 1'b1;
                    else sp[evq[i].pin] = 1'b1;
                end
            end
            if (ss >= 0) begin
                r = cyc - (mS[k] + ss);
                if (r >= 0 && r <= 1) stp = 1'b1;
            end
            if (k == 0) begin start0 = stp; stop0 = sp; end
            else        begin start1 = stp; stop1 = sp; end
            if (rst_at >= 0 && cyc == mS[k] + rst_at) begin
                rst_n = 1'b0;
                for (int kk = 0; kk < 2; kk++) begin
                    mA[kk] = -10; mS[kk] = -10; mE[kk] = -10;
                end
                #1;
                chk("rst_tx", 64'(tx0), 64'd1);
                chk("rst_busy", 64'(busy0), 64'd0);
                chk("rst_eot", 64'(eot0), 64'd0);
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        start0 = 1'b0; start1 = 1'b0; stop0 = 2'b00; stop1 = 2'b00;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("reset_tx0", 64'(tx0), 64'd1);
        chk("reset_busy0", 64'(busy0), 64'd0);
        chk("reset_eot0", 64'(eot0), 64'd0);
        chk("reset_tx1", 64'(tx1), 64'd1);
        chk("reset_busy1", 64'(busy1), 64'd0);
        chk("reset_eot1", 64'(eot1), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Two channels at +10 and +25
        evq.delete(); add(10, 0); add(25, 1);
        setup(0);
        chk_frame("t1_frame", 0, 64'hA3_00_0A_00_19, 5);
        chk("t1_send_len", 64'(mE[0] - mS[0]), 64'd200);
        drive(0, -1, -1);

        // 8-bit counter, channel 1 never fires: timeout
        evq.delete(); add(10, 0);
        setup(1);
        chk_frame("t2_frame", 1, 64'hA1_0A_FF, 3);
        chk("t2_busy_len", 64'(mE[1] - mA[1]), 64'd376);
        drive(1, -1, -1);

        // Only the first edge per channel counts
        evq.delete(); add(5, 0); add(9, 0); add(30, 0); add(7, 1);
        setup(0);
        chk_frame("t3_frame", 0, 64'hA3_00_05_00_07, 5);
        drive(0, -1, -1);

        // IDLE stops ignored, simultaneous stops, start during SEND ignored
        evq.delete(); add(-8, 0); add(-6, 1); add(-4, 0); add(0, 1); add(3, 0); add(3, 1);
        setup(0);
        chk_frame("t4_frame", 0, 64'hA3_00_03_00_03, 5);
        drive(0, 30, -1);

        // Reset in the middle of byte 2, then a clean measurement
        evq.delete(); add(10, 0); add(25, 1);
        setup(0);
        drive(0, -1, 85);
        @(posedge clk); #1;
        evq.delete(); add(10, 0); add(25, 1);
        setup(0);
        drive(0, -1, -1);

        // Timeout boundary: edge on the saturating cycle still captures 255
        evq.delete(); add(256, 0);
        setup(1);
        chk_frame("t7_frame", 1, 64'hA1_FF_FF, 3);
        drive(1, -1, -1);
        evq.delete(); add(257, 0);
        setup(1);
        chk_frame("t8_frame", 1, 64'hA0_FF_FF, 3);
        drive(1, -1, -1);
        evq.delete(); add(255, 0); add(254, 1);
        setup(1);
        chk_frame("t9_frame", 1, 64'hA3_FF_FE, 3);
        drive(1, -1, -1);
        evq.delete(); add(1, 0); add(1, 1);
        setup(1);
        chk_frame("t10_frame", 1, 64'hA3_01_01, 3);
        drive(1, -1, -1);

        // Randomised measurements on both instances
        for (int it = 0; it < 14; it++) begin
            int k, dd;
            k = it % 2;
            evq.delete();
            if ($urandom_range(0, 1) == 1) add(-8, int'($urandom_range(0, 1)));
            for (int c = 0; c < 2; c++) begin
                if (k == 0) begin
                    dd = int'($urandom_range(1, 60));
                    add(dd, c);
                    if ($urandom_range(0, 1) == 1) add(dd + 3 + int'($urandom_range(0, 20)), c);
                end else if ($urandom_range(0, 3) != 0) begin
                    dd = int'($urandom_range(1, 300));
                    add(dd, c);
                end
            end
            setup(k);
            drive(k, (k == 0) ? int'($urandom_range(0, 100)) : int'($urandom_range(0, 90)), -1);
        end

        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
